// File: rtl/tilexy_reqmort_sink.sv
// Request-line sink: buffers cluster FIFO lines and unrolls fills into BEATS x BEAT_W cache beats,
// with expunges on a separate one-shot port. Optional stat counters under TILEXY_SINK_STAT_EN.
module tilexy_reqmort_sink #(
    parameter int DEPTH  = 4,
    parameter int BEATS  = 8,
    parameter int BEAT_W = 66,
    parameter int AFULL  = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_en,
    input  logic [BEATS*BEAT_W-1:0]   in_data,
    input  logic [36:0]               in_addr,
    input  logic [41:0]               in_size,
    input  logic                      in_expun,
    output logic                      almost_full,
    output logic                      ovf,
    output logic                      wr_en,
    input  logic                      wr_ready,
    output logic [BEAT_W-1:0]         wr_data,
    output logic [36:0]               wr_addr,
    output logic [$clog2(BEATS)-1:0]  wr_beat,
    output logic                      wr_last,
    output logic                      wr_shared,
    output logic                      wr_excl,
    output logic [39:0]               wr_phymsk,
    output logic                      ex_en,
    input  logic                      ex_ready,
    output logic [36:0]               ex_addr
`ifdef TILEXY_SINK_STAT_EN
    ,
    output logic [15:0]               stat_lines,
    output logic [15:0]               stat_drops
`endif
);

    localparam int LINE_W  = BEATS * BEAT_W;
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int BEAT_CW = $clog2(BEATS);

    typedef struct packed {
        logic              expun;
        logic [41:0]       size;
        logic [36:0]       addr;
        logic [LINE_W-1:0] data;
    } entry_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BEAT,
        S_EXPUN
    } state_t;

    entry_t             r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_almost_full;
    logic               r_ovf;

    state_t             r_state;
    state_t             w_state_next;

    logic [LINE_W-1:0]  r_line;
    logic [36:0]        r_addr;
    logic [41:0]        r_size;
    logic [BEAT_CW-1:0] r_beat;
    logic               r_last;
    logic               r_wr_en;
    logic               r_ex_en;

    logic               w_push;
    logic               w_drop;
    logic               w_pop;
    logic               w_beat_hs;
    logic               w_last_hs;
    logic [CNT_W-1:0]   w_count_next;
    entry_t             w_head;

    // The full check uses the registered count, so a same-cycle pop never makes room for a push.
    assign w_push    = in_en && (r_count != CNT_W'(DEPTH));
    assign w_drop    = in_en && !w_push;
    assign w_pop     = (r_state == S_IDLE) && (r_count != '0);
    assign w_head    = r_mem[r_rd_ptr];
    assign w_beat_hs = (r_state == S_BEAT) && wr_ready;
    assign w_last_hs = w_beat_hs && (r_beat == BEAT_CW'(BEATS-1));

    // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop)
            w_count_next = r_count + CNT_W'(1);
        else if (!w_push && w_pop)
            w_count_next = r_count - CNT_W'(1);
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_pop) w_state_next = w_head.expun ? S_EXPUN : S_BEAT;
            S_BEAT:  if (w_last_hs) w_state_next = S_IDLE;
            S_EXPUN: if (ex_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // NOTE: the line storage has no reset; count and pointers define validity, so its contents never matter after reset.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= '{expun: in_expun, size: in_size, addr: in_addr, data: in_data};
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_almost_full <= 1'b0;
            r_ovf         <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_drop) r_ovf    <= 1'b1;
            r_count       <= w_count_next;
            r_almost_full <= (w_count_next >= CNT_W'(DEPTH-AFULL));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_wr_en <= 1'b0;
            r_ex_en <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_wr_en <= (w_state_next == S_BEAT);
            r_ex_en <= (w_state_next == S_EXPUN);
        end
    end

    // The working line shifts down one beat per handshake, so wr_data is always its low slice.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_line <= '0;
            r_addr <= '0;
            r_size <= '0;
            r_beat <= '0;
            r_last <= 1'b0;
        end else if (w_pop) begin
            r_line <= w_head.data;
            r_addr <= w_head.addr;
            r_size <= w_head.size;
            r_beat <= '0;
            r_last <= 1'b0;
        end else if (w_beat_hs) begin
            r_line <= r_line >> BEAT_W;
            if (w_last_hs) begin
                r_beat <= '0;
                r_last <= 1'b0;
            end else begin
                r_beat <= r_beat + BEAT_CW'(1);
                r_last <= (r_beat == BEAT_CW'(BEATS-2));
            end
        end
    end

`ifdef TILEXY_SINK_STAT_EN
    logic [15:0] r_stat_lines;
    logic [15:0] r_stat_drops;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_lines <= '0;
            r_stat_drops <= '0;
        end else begin
            if (w_last_hs && (r_stat_lines != 16'hFFFF)) r_stat_lines <= r_stat_lines + 16'd1;
            if (w_drop && (r_stat_drops != 16'hFFFF))    r_stat_drops <= r_stat_drops + 16'd1;
        end
    end

    assign stat_lines = r_stat_lines;
    assign stat_drops = r_stat_drops;
`endif

    assign almost_full = r_almost_full;
    assign ovf         = r_ovf;
    assign wr_en       = r_wr_en;
    assign wr_data     = r_line[BEAT_W-1:0];
    assign wr_addr     = r_addr;
    assign wr_beat     = r_beat;
    assign wr_last     = r_last;
    assign wr_shared   = r_size[41];
    assign wr_excl     = r_size[40];
    assign wr_phymsk   = r_size[39:0];
    assign ex_en       = r_ex_en;
    assign ex_addr     = r_addr;

endmodule

// File: tb/tb_tilexy_reqmort_sink.sv
// Bench for tilexy_reqmort_sink: scenario tasks plus an in-order scoreboard of accepted lines
// that every fill beat and expunge handshake is checked against.
module tb_tilexy_reqmort_sink;

    localparam int DEPTH  = 4;
    localparam int BEATS  = 8;
    localparam int BEAT_W = 66;
    localparam int AFULL  = 1;
    localparam int LINE_W = BEATS * BEAT_W;

    typedef struct {
        logic [LINE_W-1:0] data;
        logic [36:0]       addr;
        logic [41:0]       size;
        logic              expun;
    } line_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_en;
    logic [LINE_W-1:0] in_data;
    logic [36:0]       in_addr;
    logic [41:0]       in_size;
    logic              in_expun;
    logic              almost_full;
    logic              ovf;
    logic              wr_en;
    logic              wr_ready;
    logic [BEAT_W-1:0] wr_data;
    logic [36:0]       wr_addr;
    logic [2:0]        wr_beat;
    logic              wr_last;
    logic              wr_shared;
    logic              wr_excl;
    logic [39:0]       wr_phymsk;
    logic              ex_en;
    logic              ex_ready;
    logic [36:0]       ex_addr;
`ifdef TILEXY_SINK_STAT_EN
    logic [15:0]       stat_lines;
    logic [15:0]       stat_drops;
`endif

    tilexy_reqmort_sink #(.DEPTH(DEPTH), .BEATS(BEATS), .BEAT_W(BEAT_W), .AFULL(AFULL)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_en      (in_en),
        .in_data    (in_data),
        .in_addr    (in_addr),
        .in_size    (in_size),
        .in_expun   (in_expun),
        .almost_full(almost_full),
        .ovf        (ovf),
        .wr_en      (wr_en),
        .wr_ready   (wr_ready),
        .wr_data    (wr_data),
        .wr_addr    (wr_addr),
        .wr_beat    (wr_beat),
        .wr_last    (wr_last),
        .wr_shared  (wr_shared),
        .wr_excl    (wr_excl),
        .wr_phymsk  (wr_phymsk),
        .ex_en      (ex_en),
        .ex_ready   (ex_ready),
        .ex_addr    (ex_addr)
`ifdef TILEXY_SINK_STAT_EN
        ,
        .stat_lines (stat_lines),
        .stat_drops (stat_drops)
`endif
    );

    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_pass   = 0;
    int    lines_done = 0;
    int    exp_beat = 0;
    line_t exp_q[$];
    line_t mon_cur;
    logic [BEAT_W-1:0] mon_data;

    function automatic line_t rand_line(input bit expun);
        line_t l;
        for (int w = 0; w < 16; w++) l.data[w*32 +: 32] = $urandom;
        l.data[LINE_W-1:512] = 16'($urandom);
        l.addr  = {5'($urandom), $urandom};
        l.size  = {10'($urandom), $urandom};
        l.expun = expun;
        return l;
    endfunction

    task automatic drive_fields(input line_t l);
        in_data  = l.data;
        in_addr  = l.addr;
        in_size  = l.size;
        in_expun = l.expun;
    endtask

    // One in_en cycle; lines expected to be accepted join the scoreboard.
    task automatic put_line(input line_t l, input bit accept);
        drive_fields(l);
        in_en = 1'b1;
        if (accept) exp_q.push_back(l);
        @(posedge clk); #1;
        in_en = 1'b0;
    endtask

    task automatic wait_drain(input int budget, output bit ok);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        ok = (exp_q.size() == 0);
    endtask

    // Scoreboard: a handshake is committed at the next rising edge, so it is judged on the falling edge before it.
    always @(negedge clk) begin
        if (!rst) begin
            if (wr_en || ex_en) begin
                n_checks++;
                if (wr_en && ex_en) $display("FAIL both_en: wr_en=1 ex_en=1, want only one");
                else n_pass++;
            end
            if (wr_en && wr_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL fill_beat: unexpected beat %0d data=%h, no line pending", wr_beat, wr_data);
                end else if (exp_q[0].expun) begin
                    $display("FAIL fill_order: got fill beat addr=%h, want expunge addr=%h", wr_addr, exp_q[0].addr);
                end else begin
                    mon_cur  = exp_q[0];
                    mon_data = mon_cur.data[exp_beat*BEAT_W +: BEAT_W];
                    if (wr_data !== mon_data || wr_beat !== 3'(exp_beat) || wr_last !== (exp_beat == BEATS-1) ||
                        wr_addr !== mon_cur.addr || wr_shared !== mon_cur.size[41] ||
                        wr_excl !== mon_cur.size[40] || wr_phymsk !== mon_cur.size[39:0])
                        $display("FAIL fill_beat: got beat=%0d last=%b data=%h addr=%h size=%b%b%h, want beat=%0d last=%b data=%h addr=%h size=%h",
                                 wr_beat, wr_last, wr_data, wr_addr, wr_shared, wr_excl, wr_phymsk,
                                 exp_beat, (exp_beat == BEATS-1), mon_data, mon_cur.addr, mon_cur.size);
                    else n_pass++;
                    exp_beat++;
                    if (exp_beat == BEATS) begin
                        exp_beat = 0;
                        void'(exp_q.pop_front());
                        lines_done++;
                    end
                end
            end
            if (ex_en && ex_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL expunge: unexpected ex_addr=%h, nothing pending", ex_addr);
                end else if (!exp_q[0].expun || exp_beat != 0) begin
                    $display("FAIL expunge_order: got expunge addr=%h, want fill addr=%h", ex_addr, exp_q[0].addr);
                end else begin
                    if (ex_addr !== exp_q[0].addr)
                        $display("FAIL expunge_addr: got %h, want %h", ex_addr, exp_q[0].addr);
                    else n_pass++;
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (wr_en !== 1'b0)       $display("FAIL rst_wr_en: got %b, want 0", wr_en);             else n_pass++;
        n_checks++; if (ex_en !== 1'b0)       $display("FAIL rst_ex_en: got %b, want 0", ex_en);             else n_pass++;
        n_checks++; if (ovf !== 1'b0)         $display("FAIL rst_ovf: got %b, want 0", ovf);                 else n_pass++;
        n_checks++; if (almost_full !== 1'b0) $display("FAIL rst_afull: got %b, want 0", almost_full);       else n_pass++;
        n_checks++; if (wr_beat !== 3'd0 || wr_last !== 1'b0)
                        $display("FAIL rst_beat: got beat=%0d last=%b, want 0 0", wr_beat, wr_last);         else n_pass++;
        n_checks++; if (wr_data !== '0 || wr_addr !== '0 || ex_addr !== '0)
                        $display("FAIL rst_data: got data=%h addr=%h ex=%h, want 0", wr_data, wr_addr, ex_addr); else n_pass++;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single_fill();
        line_t l;
        bit    ok;
        l = rand_line(1'b0);
        l.addr = 37'h1_2345_6780;
        for (int k = 0; k < BEATS; k++) l.data[k*BEAT_W +: BEAT_W] = 66'(k + 1);
        wr_ready = 1'b1;
        put_line(l, 1'b1);
        n_checks++; if (wr_en !== 1'b0) $display("FAIL single_latency: wr_en=%b one cycle after in_en, want 0", wr_en); else n_pass++;
        @(posedge clk); #1;
        for (int k = 0; k < BEATS; k++) begin
            n_checks++;
            if (wr_en !== 1'b1 || wr_beat !== 3'(k) || wr_data !== 66'(k + 1) ||
                wr_last !== (k == BEATS-1) || wr_addr !== 37'h1_2345_6780)
                $display("FAIL single_beat%0d: got en=%b beat=%0d data=%h last=%b addr=%h, want 1 %0d %h %b 1234567 80",
                         k, wr_en, wr_beat, wr_data, wr_last, wr_addr, k, 66'(k + 1), (k == BEATS-1));
            else n_pass++;
            @(posedge clk); #1;
        end
        n_checks++; if (wr_en !== 1'b0) $display("FAIL single_bubble: wr_en=%b after beat 7, want 0", wr_en); else n_pass++;
        wait_drain(20, ok);
        n_checks++; if (!ok) $display("FAIL single_drain: %0d lines left, want 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_backpressure();
        line_t l;
        bit    ok;
        bit    found;
        l = rand_line(1'b0);
        wr_ready = 1'b1;
        put_line(l, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (wr_en && wr_beat == 3'd3) found = 1'b1;
            else begin @(posedge clk); #1; end
        end
        n_checks++; if (!found) $display("FAIL bp_reach: beat 3 not seen, want within 20 cycles"); else n_pass++;
        wr_ready = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            n_checks++;
            if (wr_en !== 1'b1 || wr_beat !== 3'd3 || wr_data !== l.data[3*BEAT_W +: BEAT_W])
                $display("FAIL bp_hold: got en=%b beat=%0d data=%h, want 1 3 %h", wr_en, wr_beat, wr_data, l.data[3*BEAT_W +: BEAT_W]);
            else n_pass++;
        end
        wr_ready = 1'b1;
        wait_drain(30, ok);
        n_checks++; if (!ok) $display("FAIL bp_drain: %0d lines left, want 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_expunge_mix();
        line_t a, b, c;
        bit    ok;
        bit    found;
        int    d;
        a = rand_line(1'b0);
        b = rand_line(1'b1);
        c = rand_line(1'b0);
        wr_ready = 1'b1;
        ex_ready = 1'b0;
        put_line(a, 1'b1);
        put_line(b, 1'b1);
        put_line(c, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (ex_en) found = 1'b1;
            else begin @(posedge clk); #1; end
        end
        n_checks++; if (!found) $display("FAIL ex_reach: ex_en not seen, want within 40 cycles"); else n_pass++;
        d = $urandom_range(1, 4);
        for (int i = 0; i < d; i++) begin
            n_checks++;
            if (ex_en !== 1'b1 || wr_en !== 1'b0 || ex_addr !== b.addr)
                $display("FAIL ex_hold: got ex_en=%b wr_en=%b addr=%h, want 1 0 %h", ex_en, wr_en, ex_addr, b.addr);
            else n_pass++;
            @(posedge clk); #1;
        end
        ex_ready = 1'b1;
        @(posedge clk); #1;
        ex_ready = 1'b0;
        n_checks++; if (ex_en !== 1'b0) $display("FAIL ex_release: ex_en=%b after ex_ready, want 0", ex_en); else n_pass++;
        wait_drain(30, ok);
        n_checks++; if (!ok) $display("FAIL ex_drain: %0d entries left, want 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_overflow();
        line_t l;
        bit    ok;
        int    exp_cnt;
        wr_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            l = rand_line(1'b0);
            // With the engine stalled, the first line moves to the working register and the rest fill DEPTH slots.
            put_line(l, k <= DEPTH);
            exp_cnt = (k == 0) ? 1 : ((k < DEPTH) ? k : DEPTH);
            n_checks++;
            if (almost_full !== (exp_cnt >= DEPTH-AFULL) || ovf !== (k > DEPTH))
                $display("FAIL ovf_push%0d: got afull=%b ovf=%b, want %b %b", k, almost_full, ovf, (exp_cnt >= DEPTH-AFULL), (k > DEPTH));
            else n_pass++;
        end
        wr_ready = 1'b1;
        wait_drain(120, ok);
        n_checks++; if (!ok) $display("FAIL ovf_drain: %0d lines left, want 0", exp_q.size()); else n_pass++;
        n_checks++; if (ovf !== 1'b1 || almost_full !== 1'b0)
                        $display("FAIL ovf_sticky: got ovf=%b afull=%b, want 1 0", ovf, almost_full); else n_pass++;
`ifdef TILEXY_SINK_STAT_EN
        n_checks++; if (stat_drops !== 16'd1) $display("FAIL stat_drops: got %0d, want 1", stat_drops); else n_pass++;
        n_checks++; if (stat_lines !== 16'(lines_done)) $display("FAIL stat_lines: got %0d, want %0d", stat_lines, lines_done); else n_pass++;
`endif
    endtask

    task automatic test_async_reset();
        line_t l;
        bit    ok;
        bit    found;
        wr_ready = 1'b0;
        for (int k = 0; k < 4; k++) put_line(rand_line(1'b0), 1'b1);
        n_checks++; if (almost_full !== 1'b1 || ovf !== 1'b1)
                        $display("FAIL arst_pre: got afull=%b ovf=%b, want 1 1", almost_full, ovf); else n_pass++;
        wr_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (wr_en && wr_beat == 3'd5) found = 1'b1;
            else begin @(posedge clk); #1; end
        end
        n_checks++; if (!found) $display("FAIL arst_reach: beat 5 not seen, want within 30 cycles"); else n_pass++;
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if (wr_en !== 1'b0 || ex_en !== 1'b0 || almost_full !== 1'b0 || ovf !== 1'b0 || wr_beat !== 3'd0 || wr_last !== 1'b0)
            $display("FAIL arst_out: got en=%b ex=%b afull=%b ovf=%b beat=%0d last=%b, want all 0",
                     wr_en, ex_en, almost_full, ovf, wr_beat, wr_last);
        else n_pass++;
`ifdef TILEXY_SINK_STAT_EN
        n_checks++; if (stat_lines !== 16'd0 || stat_drops !== 16'd0)
                        $display("FAIL arst_stat: got %0d %0d, want 0 0", stat_lines, stat_drops); else n_pass++;
`endif
        exp_q.delete();
        exp_beat = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        l = rand_line(1'b0);
        put_line(l, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 5 && !found; i++) begin
            if (wr_en) found = 1'b1;
            else begin @(posedge clk); #1; end
        end
        n_checks++;
        if (!found || wr_beat !== 3'd0 || wr_data !== l.data[BEAT_W-1:0])
            $display("FAIL arst_restart: got en=%b beat=%0d data=%h, want 1 0 %h", wr_en, wr_beat, wr_data, l.data[BEAT_W-1:0]);
        else n_pass++;
        wait_drain(20, ok);
        n_checks++; if (!ok) $display("FAIL arst_drain: %0d lines left, want 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_wrap();
        bit ok;
        int start;
        start = lines_done;
        wr_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            for (int w = 0; w < 50 && almost_full; w++) begin @(posedge clk); #1; end
            put_line(rand_line(1'b0), 1'b1);
        end
        wait_drain(200, ok);
        n_checks++; if (!ok) $display("FAIL wrap_drain: %0d lines left, want 0", exp_q.size()); else n_pass++;
        n_checks++; if (lines_done - start != 12) $display("FAIL wrap_count: got %0d lines, want 12", lines_done - start); else n_pass++;
        n_checks++; if (ovf !== 1'b0) $display("FAIL wrap_ovf: got %b, want 0", ovf); else n_pass++;
    endtask

    task automatic test_random();
        bit    ok;
        int    sent;
        line_t l;
        sent = 0;
        for (int cyc = 0; cyc < 4000 && sent < 40; cyc++) begin
            wr_ready = ($urandom_range(0, 3) != 0);
            ex_ready = 1'($urandom_range(0, 1));
            if (!almost_full && $urandom_range(0, 1) == 1) begin
                l = rand_line($urandom_range(0, 3) == 0);
                drive_fields(l);
                in_en = 1'b1;
                exp_q.push_back(l);
                sent++;
            end else begin
                in_en = 1'b0;
            end
            @(posedge clk); #1;
        end
        in_en    = 1'b0;
        wr_ready = 1'b1;
        ex_ready = 1'b1;
        wait_drain(600, ok);
        ex_ready = 1'b0;
        n_checks++; if (sent != 40) $display("FAIL rand_sent: got %0d, want 40", sent); else n_pass++;
        n_checks++; if (!ok) $display("FAIL rand_drain: %0d entries left, want 0", exp_q.size()); else n_pass++;
        n_checks++; if (ovf !== 1'b0) $display("FAIL rand_ovf: got %b, want 0", ovf); else n_pass++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        in_en    = 1'b0;
        in_data  = '0;
        in_addr  = '0;
        in_size  = '0;
        in_expun = 1'b0;
        wr_ready = 1'b0;
        ex_ready = 1'b0;
        test_reset();
        test_single_fill();
        test_backpressure();
        test_expunge_mix();
        test_overflow();
        test_async_reset();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
